acc_cpu_mc: RTL and testbench
=============================

Name: acc_cpu_mc

Overview:
- Parametrised multi-cycle accumulator CPU; next generation of the team's fetch/decode/execute core.
- Adds external synchronous instruction and data memories, an accumulator with Z/C flags, branches, load/store, a run/stall input and a halt state.
- Sits between the instruction ROM and data RAM; the test harness observes `result`.

Parameters:
- DATA_W, 8, accumulator/data-memory word width (>=4)
- ADDR_W, 8, PC and data-address width; instruction operand width
- INSTR_W, 4+ADDR_W, instruction width (derived, not overridable): opcode [INSTR_W-1:ADDR_W], operand [ADDR_W-1:0]

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- run  in  1  when low, core stalls at next instruction boundary
- imem_addr  out  ADDR_W  = pc, combinational
- imem_rdata  in  INSTR_W  instruction, valid 1 cycle after address sampled
- dmem_addr  out  ADDR_W  data address
- dmem_rdata  in  DATA_W  read data, 1-cycle latency
- dmem_wdata  out  DATA_W  = acc
- dmem_we  out  1  write strobe, 1 cycle
- result  out  DATA_W  last OUT value
- result_valid  out  1  1-cycle pulse per OUT
- halted  out  1  high in HALT

Behaviour:
- Reset: pc=0, acc=0, Z=0, C=0, ir=0, result=0, result_valid=0, dmem_we=0, halted=0, dmem_addr=0, state=FETCH. Reset overrides everything, including mid-instruction or in HALT; no pending write completes.
- FSM states and transitions:
  - FETCH: if run, go to DECODE; else stay. imem samples pc.
  - DECODE: ir<=imem_rdata; pc<=pc+1 (mod 2^ADDR_W, wraps to 0); go to EXEC.
  - EXEC: execute ir per opcodes below. Memory-read ops drive dmem_addr=arg and go to MEM; all others go to FETCH.
  - MEM: capture dmem_rdata, complete the op, go to FETCH.
  - HALT: terminal until reset.
- Timing:
  - Non-memory instruction: 3 cycles.
  - Memory-read instruction: 4 cycles.
  - result_valid and dmem_we asserted for exactly the EXEC cycle's following clock, i.e. registered 1-cycle pulses.
- Opcodes (arg = ir[ADDR_W-1:0]):
  - 0 NOP.
  - 1 LDI: acc<=arg zero-extended/truncated to DATA_W.
  - 2 LDA: acc<=M[arg].
  - 3 STA: M[arg]<=acc, dmem_we pulse, no flag change.
  - 4 ADD: {C,acc}<=acc+M[arg].
  - 5 SUB: acc<=acc-M[arg], C=borrow.
  - 6 AND.
  - 7 OR.
  - 8 XOR: each with M[arg], C unchanged.
  - 9 JMP: pc<=arg.
  - A JZ: pc<=arg if Z.
  - B JC: pc<=arg if C.
  - C OUT: result<=acc, result_valid pulse.
  - F HLT: go to HALT.
  - D, E: NOP.
- Flags:
  - Z updated on every acc write (acc==0).
  - C updated by ADD/SUB only.
  - Branch reads flags as of before this instruction.
- Jump target overrides the pc+1 from DECODE.
- Width rules: all arithmetic modulo 2^DATA_W; carry is bit DATA_W of the unsigned sum.
- run low mid-instruction: the instruction completes; stall occurs only in FETCH. Outputs hold while stalled.

Decomposition:
- Package acc_cpu_pkg: opcode localparams (OP_NOP..OP_HLT), state enum (S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT).
- One sub-module acc_cpu_alu:
  - Combinational.
  - Inputs: op, a, b.
  - Outputs: y, c_out, z.
- FSM, pc, ir and flags live in top.

Test Plan:
- Reset held 2 cycles, then program LDI 0x05; OUT; HLT -> result=0x05 with a single result_valid pulse at cycle 6 after reset release; halted=1 from cycle 9 onward; pc=3.
- M[0x10]=0x02; LDI 0xFF; ADD 0x10; JC 0x08; at 0x08 OUT -> result=0x01, C=1, Z=0; ADD takes 4 cycles.
- LDI 0x03; SUB 0x11 (M=0x03); JZ 0x20; STA 0x30 at 0x20 -> dmem_we one cycle with addr 0x30, wdata 0x00; Z=1, C=0.
- JMP 0xFF; at 0xFF NOP; at 0x00 LDI 0x07 -> pc wraps 0xFF->0x00, and LDI re-executes with acc=0x07.
- run deasserted during EXEC of an ADD -> ADD completes, FSM parks in FETCH with pc unchanged; run reasserted -> next fetch resumes.
- Reset asserted in MEM of an LDA, and again while in HALT -> all outputs return to reset values next cycle; execution restarts at pc=0.

Source files
------------

// File: rtl/acc_cpu_pkg.sv
// Shared opcode encodings, FSM state type and small decode helpers for the
// multi-cycle accumulator core.
package acc_cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JC  = 4'hB;
    localparam logic [3:0] OP_OUT = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    // Opcodes that need a data-memory read before they can complete.
    function automatic logic is_mem_read(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_AND) || (op == OP_OR)  || (op == OP_XOR);
    endfunction

    function automatic logic updates_carry(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU: add/sub with carry-borrow, bitwise ops, and a pass-through
// of operand b for the load instructions.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y,
    output logic              c_out,
    output logic              z
);

    always_comb begin
        y     = b;
        c_out = 1'b0;
        case (op)
            OP_ADD:  {c_out, y} = {1'b0, a} + {1'b0, b};
            // The extra top bit of the difference is the borrow (set when a < b).
            OP_SUB:  {c_out, y} = {1'b0, a} - {1'b0, b};
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = b;
        endcase
    end

    assign z = (y == '0);

endmodule

// File: rtl/acc_cpu_mc.sv
// Multi-cycle accumulator CPU: FETCH/DECODE/EXEC(/MEM) sequencing against
// synchronous instruction and data memories, with Z/C flags and a halt state.
module acc_cpu_mc
    import acc_cpu_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int ADDR_W  = 8,
    localparam int INSTR_W = 4 + ADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  dmem_addr,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic [DATA_W-1:0]  dmem_wdata,
    output logic               dmem_we,
    output logic [DATA_W-1:0]  result,
    output logic               result_valid,
    output logic               halted
);

    state_t               r_state;
    logic [ADDR_W-1:0]    r_pc;
    logic [INSTR_W-1:0]   r_ir;
    logic [DATA_W-1:0]    r_acc;
    logic                 r_z;
    logic                 r_c;
    logic [DATA_W-1:0]    r_result;
    logic                 r_result_valid;
    logic                 r_dmem_we;
    logic [ADDR_W-1:0]    r_dmem_addr;
    logic                 r_halted;

    logic [3:0]           w_op;
    logic [ADDR_W-1:0]    w_arg;
    logic [DATA_W-1:0]    w_arg_d;
    logic [DATA_W-1:0]    w_alu_b;
    logic [DATA_W-1:0]    w_alu_y;
    logic                 w_alu_c;
    logic                 w_alu_z;

    assign w_op  = r_ir[INSTR_W-1:ADDR_W];
    assign w_arg = r_ir[ADDR_W-1:0];

    // Immediate operand fitted to the data width (zero-extend or truncate).
    generate
        if (DATA_W > ADDR_W) begin : g_arg_ext
            assign w_arg_d = {{(DATA_W-ADDR_W){1'b0}}, w_arg};
        end else begin : g_arg_trunc
            assign w_arg_d = w_arg[DATA_W-1:0];
        end
    endgenerate

    // In MEM the second operand is the word just read; in EXEC it is the immediate.
    assign w_alu_b = (r_state == S_MEM) ? dmem_rdata : w_arg_d;

    acc_cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op    (w_op),
        .a     (r_acc),
        .b     (w_alu_b),
        .y     (w_alu_y),
        .c_out (w_alu_c),
        .z     (w_alu_z)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_FETCH;
            r_pc           <= '0;
            r_ir           <= '0;
            r_acc          <= '0;
            r_z            <= 1'b0;
            r_c            <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_dmem_we      <= 1'b0;
            r_dmem_addr    <= '0;
            r_halted       <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_dmem_we      <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (run) begin
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_ir        <= imem_rdata;
                    r_pc        <= r_pc + ADDR_W'(1);
                    // Address is presented during EXEC so a read lands in MEM.
                    r_dmem_addr <= imem_rdata[ADDR_W-1:0];
                    r_state     <= S_EXEC;
                end
                S_EXEC: begin
                    r_state <= S_FETCH;
                    if (is_mem_read(w_op)) begin
                        r_state <= S_MEM;
                    end
                    case (w_op)
                        OP_LDI: begin
                            r_acc <= w_alu_y;
                            r_z   <= w_alu_z;
                        end
                        OP_STA: r_dmem_we <= 1'b1;
                        OP_JMP: r_pc <= w_arg;
                        OP_JZ: begin
                            if (r_z) begin
                                r_pc <= w_arg;
                            end
                        end
                        OP_JC: begin
                            if (r_c) begin
                                r_pc <= w_arg;
                            end
                        end
                        OP_OUT: begin
                            r_result       <= r_acc;
                            r_result_valid <= 1'b1;
                        end
                        OP_HLT: begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                S_MEM: begin
                    r_acc <= w_alu_y;
                    r_z   <= w_alu_z;
                    if (updates_carry(w_op)) begin
                        r_c <= w_alu_c;
                    end
                    r_state <= S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign imem_addr    = r_pc;
    assign dmem_addr    = r_dmem_addr;
    assign dmem_wdata   = r_acc;
    assign dmem_we      = r_dmem_we;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign halted       = r_halted;

endmodule

// File: tb/tb_acc_cpu_mc.sv
// Directed bench for acc_cpu_mc with behavioural synchronous instruction/data
// memories and a queue of expected OUT values.
module tb_acc_cpu_mc;
    import acc_cpu_pkg::*;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 4 + ADDR_W;

    logic               clk = 1'b0;
    logic               reset;
    logic               run;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [ADDR_W-1:0]  dmem_addr;
    logic [DATA_W-1:0]  dmem_rdata;
    logic [DATA_W-1:0]  dmem_wdata;
    logic               dmem_we;
    logic [DATA_W-1:0]  result;
    logic               result_valid;
    logic               halted;

    logic [INSTR_W-1:0] imem [256];
    logic [DATA_W-1:0]  dmem [256];
    logic [DATA_W-1:0]  exp_q [$];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int we_cnt   = 0;
    logic [ADDR_W-1:0] we_addr;
    logic [DATA_W-1:0] we_data;

    acc_cpu_mc #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .dmem_addr    (dmem_addr),
        .dmem_rdata   (dmem_rdata),
        .dmem_wdata   (dmem_wdata),
        .dmem_we      (dmem_we),
        .result       (result),
        .result_valid (result_valid),
        .halted       (halted)
    );

    // Clock and memories
    always #5 clk = ~clk;

    always @(posedge clk) begin
        imem_rdata <= imem[imem_addr];
        dmem_rdata <= dmem[dmem_addr];
        if (dmem_we) begin
            dmem[dmem_addr] <= dmem_wdata;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic clear_mems();
        for (int i = 0; i < 256; i++) begin
            imem[i] = '0;
            dmem[i] = '0;
        end
        exp_q.delete();
        we_cnt = 0;
    endtask

    task automatic prog(input int a, input logic [3:0] op, input logic [7:0] arg);
        imem[a] = {op, arg};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
    endtask

    // One clock; samples on the falling edge and scores OUT/write activity.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (result_valid) begin
            check("out_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("out_value", 32'(result), 32'(exp_q.pop_front()));
            end
        end
        if (dmem_we) begin
            we_cnt++;
            we_addr = dmem_addr;
            we_data = dmem_wdata;
        end
    endtask

    task automatic run_to_halt(input int max_cycles);
        int n = 0;
        while (!halted && n < max_cycles) begin
            step();
            n++;
        end
        check("halt_reached", 32'(halted), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        run   = 1'b1;

        // LDI 5; OUT; HLT with exact timing
        clear_mems();
        prog(0, OP_LDI, 8'h05);
        prog(1, OP_OUT, 8'h00);
        prog(2, OP_HLT, 8'h00);
        exp_q.push_back(8'h05);
        do_reset();
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_dmem_addr", 32'(dmem_addr), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_dmem_we", 32'(dmem_we), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_state", 32'(dut.r_state), 32'(S_FETCH));
        check("rst_acc", 32'(dut.r_acc), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("t1_rv_c%0d", k), 32'(result_valid), 32'(k == 6));
            check($sformatf("t1_halted_c%0d", k), 32'(halted), 32'(k >= 9));
        end
        check("t1_result", 32'(result), 32'h05);
        check("t1_pc", 32'(imem_addr), 32'd3);
        check("t1_out_left", 32'(exp_q.size()), 32'd0);

        // ADD with carry, then taken JC
        clear_mems();
        dmem[8'h10] = 8'h02;
        prog(0, OP_LDI, 8'hFF);
        prog(1, OP_ADD, 8'h10);
        prog(2, OP_JC,  8'h08);
        prog(3, OP_LDI, 8'h55);
        prog(4, OP_OUT, 8'h00);
        prog(5, OP_HLT, 8'h00);
        prog(8, OP_OUT, 8'h00);
        prog(9, OP_HLT, 8'h00);
        exp_q.push_back(8'h01);
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 5) check("t2_add_exec", 32'(dut.r_state), 32'(S_EXEC));
            if (k == 6) check("t2_add_mem", 32'(dut.r_state), 32'(S_MEM));
            if (k == 7) begin
                check("t2_add_done", 32'(dut.r_state), 32'(S_FETCH));
                check("t2_pc_after_add", 32'(imem_addr), 32'd2);
            end
        end
        run_to_halt(40);
        check("t2_result", 32'(result), 32'h01);
        check("t2_c", 32'(dut.r_c), 32'd1);
        check("t2_z", 32'(dut.r_z), 32'd0);
        check("t2_out_left", 32'(exp_q.size()), 32'd0);

        // SUB to zero, taken JZ, STA
        clear_mems();
        dmem[8'h11] = 8'h03;
        dmem[8'h30] = 8'hAA;
        prog(0, OP_LDI, 8'h03);
        prog(1, OP_SUB, 8'h11);
        prog(2, OP_JZ,  8'h20);
        prog(3, OP_LDI, 8'h55);
        prog(4, OP_HLT, 8'h00);
        prog(8'h20, OP_STA, 8'h30);
        prog(8'h21, OP_HLT, 8'h00);
        do_reset();
        run_to_halt(60);
        check("t3_we_cycles", 32'(we_cnt), 32'd1);
        check("t3_we_addr", 32'(we_addr), 32'h30);
        check("t3_we_data", 32'(we_data), 32'h00);
        check("t3_mem_written", 32'(dmem[8'h30]), 32'h00);
        check("t3_z", 32'(dut.r_z), 32'd1);
        check("t3_c", 32'(dut.r_c), 32'd0);
        check("t3_pc", 32'(imem_addr), 32'h22);

        // JMP to 0xFF, pc wraps to 0 and the program re-executes
        clear_mems();
        prog(0, OP_LDI, 8'h07);
        prog(1, OP_OUT, 8'h00);
        prog(2, OP_LDI, 8'h00);
        prog(3, OP_JMP, 8'hFF);
        prog(8'hFF, OP_NOP, 8'h00);
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h07);
        do_reset();
        for (int k = 1; k <= 21; k++) begin
            step();
            if (k == 12) begin
                check("t4_pc_ff", 32'(imem_addr), 32'hFF);
                check("t4_acc_cleared", 32'(dut.r_acc), 32'h00);
                check("t4_z_set", 32'(dut.r_z), 32'd1);
            end
            if (k == 14) check("t4_pc_wrap", 32'(imem_addr), 32'h00);
            if (k == 18) check("t4_acc_reload", 32'(dut.r_acc), 32'h07);
        end
        check("t4_out_left", 32'(exp_q.size()), 32'd0);

        // run dropped during EXEC of an ADD
        clear_mems();
        dmem[8'h40] = 8'h10;
        prog(0, OP_LDI, 8'h05);
        prog(1, OP_ADD, 8'h40);
        prog(2, OP_OUT, 8'h00);
        prog(3, OP_HLT, 8'h00);
        exp_q.push_back(8'h15);
        do_reset();
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k == 5) begin
                check("t5_in_exec", 32'(dut.r_state), 32'(S_EXEC));
                run = 1'b0;
            end
            if (k == 6) check("t5_mem_completes", 32'(dut.r_state), 32'(S_MEM));
            if (k == 10) begin
                check("t5_parked", 32'(dut.r_state), 32'(S_FETCH));
                check("t5_pc_held", 32'(imem_addr), 32'd2);
                check("t5_acc", 32'(dut.r_acc), 32'h15);
                check("t5_result_held", 32'(result), 32'h00);
                run = 1'b1;
            end
            if (k == 11) check("t5_resumed", 32'(dut.r_state), 32'(S_DECODE));
        end
        run_to_halt(40);
        check("t5_result", 32'(result), 32'h15);
        check("t5_out_left", 32'(exp_q.size()), 32'd0);

        // Reset during MEM of an LDA, then again while halted
        clear_mems();
        dmem[8'h50] = 8'h33;
        prog(0, OP_LDA, 8'h50);
        prog(1, OP_OUT, 8'h00);
        prog(2, OP_HLT, 8'h00);
        exp_q.push_back(8'h33);
        do_reset();
        repeat (3) step();
        check("t6_in_mem", 32'(dut.r_state), 32'(S_MEM));
        check("t6_dmem_addr", 32'(dmem_addr), 32'h50);
        reset = 1'b1;
        step();
        check("t6_rst_state", 32'(dut.r_state), 32'(S_FETCH));
        check("t6_rst_pc", 32'(imem_addr), 32'd0);
        check("t6_rst_dmem_addr", 32'(dmem_addr), 32'd0);
        check("t6_rst_acc", 32'(dut.r_acc), 32'd0);
        check("t6_rst_halted", 32'(halted), 32'd0);
        reset = 1'b0;
        cyc = 0;
        run_to_halt(40);
        check("t6_result", 32'(result), 32'h33);
        reset = 1'b1;
        step();
        check("t6_halt_rst_halted", 32'(halted), 32'd0);
        check("t6_halt_rst_result", 32'(result), 32'd0);
        check("t6_halt_rst_state", 32'(dut.r_state), 32'(S_FETCH));
        check("t6_halt_rst_pc", 32'(imem_addr), 32'd0);
        check("t6_halt_rst_rv", 32'(result_valid), 32'd0);
        reset = 1'b0;
        exp_q.push_back(8'h33);
        run_to_halt(40);
        check("t6_restart_result", 32'(result), 32'h33);
        check("t6_out_left", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
